// File: rtl/ws_cp0_ctrl.sv
// ws_cp0_ctrl: writeback-stage CP0 controller.
// Holds the WB instruction and commits exceptions, interrupts, eret, mtc0
// and tlbp/tlbr. It also muxes mfc0 readback from the CP0 register bus.
// Optional feature macro: CP0_TLB_EN. When it is defined, the TLB
// probe/read sequencer and the TLB ports are active. When it is undefined,
// tlbp/tlbr retire as single-cycle no-ops.
module ws_cp0_ctrl #(
    parameter logic [31:0] EX_ENTRY = 32'hBFC0_0380
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_to_ws_valid,
    output logic         ws_allowin,
    input  logic [31:0]  ms_pc,
    input  logic         ms_bd,
    input  logic         ms_ex,
    input  logic [4:0]   ms_excode,
    input  logic [31:0]  ms_badvaddr,
    input  logic [4:0]   ms_op,
    input  logic [7:0]   ms_c0_addr,
    input  logic [31:0]  ms_c0_wdata,
    input  logic         has_int,
    input  logic [31:0]  cp0_epc,
    input  logic [31:0]  cp0_entryhi,
    input  logic [319:0] cp0_to_ws_bus,
    output logic [242:0] ws_to_cp0_bus,
    output logic         tlb_req,
    output logic         tlb_is_read,
    output logic [31:0]  tlb_s_entryhi,
    output logic [3:0]   tlb_r_index,
    input  logic         tlb_found,
    input  logic [3:0]   tlb_index,
    input  logic [31:0]  tlb_r_hi,
    input  logic [31:0]  tlb_r_lo0,
    input  logic [31:0]  tlb_r_lo1,
    output logic [31:0]  ws_mfc0_rdata,
    output logic         ws_flush,
    output logic [31:0]  ws_flush_pc,
    output logic         ws_cp0_busy
);
    // CP0 register addresses as {rd, sel}
    localparam logic [7:0] CR_INDEX    = {5'd0,  3'd0};
    localparam logic [7:0] CR_ENTRYLO0 = {5'd2,  3'd0};
    localparam logic [7:0] CR_ENTRYLO1 = {5'd3,  3'd0};
    localparam logic [7:0] CR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CR_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CR_ENTRYHI  = {5'd10, 3'd0};
    localparam logic [7:0] CR_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CR_EPC      = {5'd14, 3'd0};

    logic        ws_valid_q, bd_q, ex_q;
    logic [31:0] pc_q, badvaddr_q, c0_wdata_q;
    logic [4:0]  excode_q;
    logic [7:0]  c0_addr_q;
    logic        mtc0_q, eret_q, tlbp_q, tlbr_q;

    logic        ex, commit, ready_go;
    logic [4:0]  excode;
    logic        wb_ex, eret_flush, mtc0_we, tlbp_we, tlbr_we;
    logic [31:0] index_data, lo0_f, lo1_f, hi_f;

    // An interrupt overrides whatever the instruction carried.
    assign ex         = ws_valid_q & (ex_q | has_int);
    assign excode     = has_int ? 5'h00 : excode_q;
    assign commit     = ws_valid_q & ready_go;
    assign ws_allowin = !ws_valid_q || ready_go;

    assign wb_ex      = commit & ex;
    assign eret_flush = commit & eret_q & !ex;
    assign mtc0_we    = commit & mtc0_q & !ex;
    assign ws_flush    = wb_ex | eret_flush;
    assign ws_flush_pc = wb_ex ? EX_ENTRY : cp0_epc;
    assign ws_cp0_busy = ws_valid_q & (mtc0_q | eret_q | tlbp_q | tlbr_q | ex);

    // WB slot: a flush kills the slot and the offered instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q  <= 1'b0;
            pc_q        <= 32'b0;
            bd_q        <= 1'b0;
            ex_q        <= 1'b0;
            excode_q    <= 5'b0;
            badvaddr_q  <= 32'b0;
            c0_addr_q   <= 8'b0;
            c0_wdata_q  <= 32'b0;
            {mtc0_q, eret_q, tlbp_q, tlbr_q} <= 4'b0;
        end else begin
            if (ws_flush)        ws_valid_q <= 1'b0;
            else if (ws_allowin) ws_valid_q <= ms_to_ws_valid;
            if (ws_allowin && ms_to_ws_valid && !ws_flush) begin
                pc_q       <= ms_pc;
                bd_q       <= ms_bd;
                ex_q       <= ms_ex;
                excode_q   <= ms_excode;
                badvaddr_q <= ms_badvaddr;
                c0_addr_q  <= ms_c0_addr;
                c0_wdata_q <= ms_c0_wdata;
                {mtc0_q, eret_q, tlbp_q, tlbr_q} <= {ms_op[4], ms_op[2], ms_op[1], ms_op[0]};
            end
        end
    end

`ifdef CP0_TLB_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} tlb_state_e;
    tlb_state_e  state_q, state_d;
    logic        found_q;
    logic [3:0]  index_q;
    logic [31:0] hi_q, lo0_q, lo1_q;

    // TLB state register and result capture (results arrive in WAIT).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            found_q <= 1'b0;
            index_q <= 4'b0;
            hi_q    <= 32'b0;
            lo0_q   <= 32'b0;
            lo1_q   <= 32'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_WAIT) begin
                found_q <= tlb_found;
                index_q <= tlb_index;
                hi_q    <= tlb_r_hi;
                lo0_q   <= tlb_r_lo0;
                lo1_q   <= tlb_r_lo1;
            end
        end
    end

    // TLB sequencing: request in IDLE, wait one cycle, commit in DONE.
    always_comb begin
        state_d  = state_q;
        tlb_req  = 1'b0;
        ready_go = 1'b1;
        case (state_q)
            S_IDLE: if (ws_valid_q && (tlbp_q || tlbr_q) && !ex) begin
                tlb_req  = 1'b1;
                ready_go = 1'b0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                ready_go = 1'b0;
                state_d  = S_DONE;
            end
            // the slot always commits here, since ready_go is high
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign tlb_is_read   = tlbr_q;
    assign tlb_s_entryhi = cp0_entryhi;
    assign tlb_r_index   = cp0_to_ws_bus[291:288];
    assign tlbp_we       = commit & tlbp_q & !ex;
    assign tlbr_we       = commit & tlbr_q & !ex;
    assign index_data    = {32{commit}} & {~found_q, 27'b0, index_q};
    assign hi_f          = {32{commit}} & hi_q;
    assign lo0_f         = {32{commit}} & lo0_q;
    assign lo1_f         = {32{commit}} & lo1_q;
    logic unused_sink;
    assign unused_sink = ms_op[3];
`else
    assign ready_go      = 1'b1;
    assign tlb_req       = 1'b0;
    assign tlb_is_read   = 1'b0;
    assign tlb_s_entryhi = 32'b0;
    assign tlb_r_index   = 4'b0;
    assign tlbp_we       = 1'b0;
    assign tlbr_we       = 1'b0;
    assign index_data    = 32'b0;
    assign hi_f          = 32'b0;
    assign lo0_f         = 32'b0;
    assign lo1_f         = 32'b0;
    logic unused_sink;
    assign unused_sink = &{1'b0, ms_op[3], cp0_entryhi, tlb_found, tlb_index,
                           tlb_r_hi, tlb_r_lo0, tlb_r_lo1};
`endif

    assign ws_to_cp0_bus = {tlbp_we, index_data, tlbr_we, lo0_f, lo1_f, hi_f,
                            mtc0_we, wb_ex, commit & bd_q,
                            {32{commit}} & pc_q, {32{commit}} & badvaddr_q,
                            {5{commit}} & excode, eret_flush,
                            {8{commit}} & c0_addr_q, {32{commit}} & c0_wdata_q};

    // mfc0 readback mux; unmapped addresses read as zero.
    always_comb begin
        ws_mfc0_rdata = 32'b0;
        case (c0_addr_q)
            CR_INDEX:    ws_mfc0_rdata = cp0_to_ws_bus[319:288];
            CR_ENTRYLO0: ws_mfc0_rdata = cp0_to_ws_bus[287:256];
            CR_ENTRYLO1: ws_mfc0_rdata = cp0_to_ws_bus[255:224];
            CR_ENTRYHI:  ws_mfc0_rdata = cp0_to_ws_bus[223:192];
            CR_STATUS:   ws_mfc0_rdata = cp0_to_ws_bus[191:160];
            CR_CAUSE:    ws_mfc0_rdata = cp0_to_ws_bus[159:128];
            CR_EPC:      ws_mfc0_rdata = cp0_to_ws_bus[127:96];
            CR_BADVADDR: ws_mfc0_rdata = cp0_to_ws_bus[95:64];
            CR_COUNT:    ws_mfc0_rdata = cp0_to_ws_bus[63:32];
            CR_COMPARE:  ws_mfc0_rdata = cp0_to_ws_bus[31:0];
            default:     ws_mfc0_rdata = 32'b0;
        endcase
    end
endmodule

// File: tb/tb_ws_cp0_ctrl.sv
// Self-checking bench for ws_cp0_ctrl: a vector table for single-cycle
// commits, plus hand sequences for flush, back-to-back and TLB corners.
module tb_ws_cp0_ctrl;
    localparam logic [4:0]  OP_MTC0 = 5'b10000, OP_MFC0 = 5'b01000, OP_ERET = 5'b00100,
                            OP_TLBP = 5'b00010, OP_TLBR = 5'b00001;
    localparam logic [31:0] EXE = 32'hBFC0_0380, EPC_IN = 32'hBFC0_2000;
    localparam logic [31:0] IDX_V = 32'h0000_0003, LO0_V = 32'h1111_0000, LO1_V = 32'h2222_0000,
                            HI_V = 32'h3333_0000, ST_V = 32'h0040_FF01, CA_V = 32'h5555_0000,
                            EPC_V = 32'h6666_0000, BV_V = 32'h7777_0000, CNT_V = 32'h8888_0000,
                            CMP_V = 32'h9999_0000;

    logic clk = 1'b0, reset = 1'b1;
    logic ms_to_ws_valid = 1'b0, ms_bd = 1'b0, ms_ex = 1'b0, has_int = 1'b0;
    logic [31:0] ms_pc = '0, ms_badvaddr = '0, ms_c0_wdata = '0, cp0_epc = EPC_IN, cp0_entryhi;
    logic [4:0]  ms_excode = '0, ms_op = '0;
    logic [7:0]  ms_c0_addr = '0;
    logic [319:0] cp0_bus = {IDX_V, LO0_V, LO1_V, HI_V, ST_V, CA_V, EPC_V, BV_V, CNT_V, CMP_V};
    logic [242:0] ws_to_cp0_bus;
    logic tlb_req, tlb_is_read, ws_allowin, ws_flush, ws_cp0_busy;
    logic [31:0] tlb_s_entryhi, ws_mfc0_rdata, ws_flush_pc;
    logic [3:0]  tlb_r_index;
    logic tlb_found = 1'b0;
    logic [3:0]  tlb_index = '0;
    logic [31:0] tlb_r_hi = '0, tlb_r_lo0 = '0, tlb_r_lo1 = '0;

    typedef struct packed {
        logic tlbp_we; logic [31:0] index_data; logic tlbr_we;
        logic [31:0] lo0; logic [31:0] lo1; logic [31:0] hi;
        logic mtc0_we; logic wb_ex; logic wb_bd;
        logic [31:0] wb_pc; logic [31:0] wb_badvaddr; logic [4:0] wb_excode;
        logic eret_flush; logic [7:0] c0_addr; logic [31:0] c0_wdata;
    } ws_bus_t;
    ws_bus_t bo;
    assign bo = ws_bus_t'(ws_to_cp0_bus);

    ws_cp0_ctrl dut (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_bd(ms_bd), .ms_ex(ms_ex), .ms_excode(ms_excode),
        .ms_badvaddr(ms_badvaddr), .ms_op(ms_op), .ms_c0_addr(ms_c0_addr),
        .ms_c0_wdata(ms_c0_wdata), .has_int(has_int), .cp0_epc(cp0_epc),
        .cp0_entryhi(cp0_entryhi), .cp0_to_ws_bus(cp0_bus), .ws_to_cp0_bus(ws_to_cp0_bus),
        .tlb_req(tlb_req), .tlb_is_read(tlb_is_read), .tlb_s_entryhi(tlb_s_entryhi),
        .tlb_r_index(tlb_r_index), .tlb_found(tlb_found), .tlb_index(tlb_index),
        .tlb_r_hi(tlb_r_hi), .tlb_r_lo0(tlb_r_lo0), .tlb_r_lo1(tlb_r_lo1),
        .ws_mfc0_rdata(ws_mfc0_rdata), .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc),
        .ws_cp0_busy(ws_cp0_busy));

    always #5 clk = ~clk;

    // Small CP0 model: EntryHi updates at the edge where mtc0 EntryHi commits.
    always @(posedge clk) begin
        if (reset) cp0_entryhi <= 32'h0;
        else if (bo.mtc0_we && bo.c0_addr == 8'h50) cp0_entryhi <= bo.c0_wdata;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic wb_ex, mtc0_we, eret, flush, busy, bd;
        logic [31:0] fpc, rdata, pc, bva, wdata;
        logic [4:0]  excode;
    } exp_t;
    typedef struct {
        logic [4:0] op; logic ex; logic [4:0] excode; logic [31:0] pc, bva;
        logic bd; logic [7:0] addr; logic [31:0] wdata; logic hint;
        exp_t e;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt[18];

    function automatic vec_t mk(logic [4:0] op, logic ex, logic [4:0] xc, logic [31:0] pc,
                                logic [31:0] bva, logic bd, logic [7:0] addr, logic [31:0] wd,
                                logic hint, logic e_ex, logic e_mtc0, logic e_eret,
                                logic e_flush, logic [31:0] e_fpc, logic [4:0] e_xc,
                                logic e_busy, logic [31:0] e_rd);
        vec_t v;
        v.op = op; v.ex = ex; v.excode = xc; v.pc = pc; v.bva = bva; v.bd = bd;
        v.addr = addr; v.wdata = wd; v.hint = hint;
        v.e.wb_ex = e_ex; v.e.mtc0_we = e_mtc0; v.e.eret = e_eret; v.e.flush = e_flush;
        v.e.fpc = e_fpc; v.e.excode = e_xc; v.e.busy = e_busy; v.e.rdata = e_rd;
        v.e.pc = pc; v.e.bva = bva; v.e.wdata = wd; v.e.bd = bd;
        return v;
    endfunction

    task automatic drive(input logic [4:0] op, input logic ex, input logic [4:0] xc,
                         input logic [31:0] pc, input logic [7:0] addr, input logic [31:0] wd);
        ms_op = op; ms_ex = ex; ms_excode = xc; ms_pc = pc; ms_c0_addr = addr;
        ms_c0_wdata = wd; ms_bd = 1'b0; ms_badvaddr = 32'h0; ms_to_ws_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        has_int = 1'b0;
        ms_op = v.op; ms_ex = v.ex; ms_excode = v.excode; ms_pc = v.pc; ms_badvaddr = v.bva;
        ms_bd = v.bd; ms_c0_addr = v.addr; ms_c0_wdata = v.wdata; ms_to_ws_valid = 1'b1;
        exp_q.push_back(v.e);
        @(negedge clk);
        ms_to_ws_valid = 1'b0;
        has_int = v.hint;
        #1;
        e = exp_q.pop_front();
        chk("wb_ex", bo.wb_ex, e.wb_ex);
        chk("mtc0_we", bo.mtc0_we, e.mtc0_we);
        chk("eret_flush", bo.eret_flush, e.eret);
        chk("ws_flush", ws_flush, e.flush);
        chk("flush_pc", ws_flush_pc, e.fpc);
        chk("wb_excode", bo.wb_excode, e.excode);
        chk("busy", ws_cp0_busy, e.busy);
        chk("mfc0_rdata", ws_mfc0_rdata, e.rdata);
        chk("wb_pc", bo.wb_pc, e.pc);
        chk("wb_badvaddr", bo.wb_badvaddr, e.bva);
        chk("c0_wdata", bo.c0_wdata, e.wdata);
        chk("wb_bd", bo.wb_bd, e.bd);
        chk("allowin", ws_allowin, 1'b1);
    endtask

`ifdef CP0_TLB_EN
    // tlbp/tlbr sequence; optional interrupt or reset injected in cycle 1.
    task automatic tlb_run(input logic rd, input logic found, input logic [3:0] idx,
                           input logic [31:0] exp_hi, input logic int_c1, input logic rst_c1);
        @(negedge clk);
        drive(rd ? OP_TLBR : OP_TLBP, 1'b0, 5'h0, 32'hBFC0_0400, 8'h0, 32'h0);
        @(negedge clk);
        ms_to_ws_valid = 1'b0;
        #1;
        chk("c0 tlb_req", tlb_req, 1'b1);
        chk("c0 is_read", tlb_is_read, rd);
        chk("c0 allowin", ws_allowin, 1'b0);
        if (rd) chk("c0 r_index", tlb_r_index, 4'd3);
        else    chk("c0 s_entryhi", tlb_s_entryhi, exp_hi);
        tlb_found = found; tlb_index = idx;
        tlb_r_hi = 32'hAAAA_0001; tlb_r_lo0 = 32'hBBBB_0002; tlb_r_lo1 = 32'hCCCC_0003;
        @(negedge clk);
        #1;
        chk("c1 tlb_req", tlb_req, 1'b0);
        chk("c1 allowin", ws_allowin, 1'b0);
        chk("c1 we", bo.tlbp_we | bo.tlbr_we, 1'b0);
        if (int_c1) has_int = 1'b1;
        if (rst_c1) reset = 1'b1;
        @(negedge clk);
        #1;
        if (rst_c1) begin
            reset = 1'b0;
            chk("rst we", bo.tlbp_we | bo.tlbr_we, 1'b0);
            chk("rst allowin", ws_allowin, 1'b1);
            chk("rst busy", ws_cp0_busy, 1'b0);
            chk("rst tlb_req", tlb_req, 1'b0);
        end else if (int_c1) begin
            chk("int wb_ex", bo.wb_ex, 1'b1);
            chk("int excode", bo.wb_excode, 5'h00);
            chk("int tlbp_we", bo.tlbp_we, 1'b0);
            chk("int flush_pc", ws_flush_pc, EXE);
            has_int = 1'b0;
        end else begin
            chk("c2 allowin", ws_allowin, 1'b1);
            chk("c2 wb_ex", bo.wb_ex, 1'b0);
            if (rd) begin
                chk("c2 tlbr_we", bo.tlbr_we, 1'b1);
                chk("c2 tlbp_we", bo.tlbp_we, 1'b0);
                chk("c2 lo0", bo.lo0, 32'hBBBB_0002);
                chk("c2 lo1", bo.lo1, 32'hCCCC_0003);
                chk("c2 hi", bo.hi, 32'hAAAA_0001);
            end else begin
                chk("c2 tlbp_we", bo.tlbp_we, 1'b1);
                chk("c2 index_data", bo.index_data,
                    found ? {28'h0, idx} : 32'h8000_0000);
            end
        end
        @(negedge clk);
        tlb_found = 1'b0; tlb_index = '0; tlb_r_hi = '0; tlb_r_lo0 = '0; tlb_r_lo1 = '0;
        #1;
        chk("c3 we", bo.tlbp_we | bo.tlbr_we, 1'b0);
        chk("c3 tlb_req", tlb_req, 1'b0);
        chk("c3 allowin", ws_allowin, 1'b1);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = mk(OP_MTC0, 0, 5'h00, 32'hBFC0_0010, 0, 0, 8'h58, 32'h100, 0, 0, 1, 0, 0, EPC_IN, 5'h00, 1, CMP_V);
        vt[1]  = mk(5'h0, 1, 5'h04, 32'hBFC0_1000, 32'h1, 0, 8'h00, 0, 0, 1, 0, 0, 1, EXE, 5'h04, 1, IDX_V);
        vt[2]  = mk(OP_ERET, 0, 5'h00, 32'hBFC0_0020, 0, 0, 8'h00, 0, 0, 0, 0, 1, 1, EPC_IN, 5'h00, 1, IDX_V);
        vt[3]  = mk(5'h0, 0, 5'h00, 32'hBFC0_0030, 0, 1, 8'h00, 0, 1, 1, 0, 0, 1, EXE, 5'h00, 1, IDX_V);
        vt[4]  = mk(OP_MTC0, 0, 5'h00, 32'hBFC0_0040, 0, 0, 8'h58, 32'h55, 1, 1, 0, 0, 1, EXE, 5'h00, 1, CMP_V);
        vt[5]  = mk(5'h0, 1, 5'h08, 32'hBFC0_0050, 0, 0, 8'h00, 0, 1, 1, 0, 0, 1, EXE, 5'h00, 1, IDX_V);
        vt[6]  = mk(OP_ERET, 1, 5'h0A, 32'hBFC0_0060, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, EXE, 5'h0A, 1, IDX_V);
        vt[7]  = mk(5'h0, 0, 5'h00, 32'hBFC0_0070, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, EPC_IN, 5'h00, 0, IDX_V);
        vt[8]  = mk(OP_MFC0, 0, 5'h00, 32'hBFC0_0080, 0, 0, 8'h60, 0, 0, 0, 0, 0, 0, EPC_IN, 5'h00, 0, ST_V);
        vt[9]  = mk(OP_MFC0, 0, 5'h00, 32'hBFC0_0084, 0, 0, 8'h68, 0, 0, 0, 0, 0, 0, EPC_IN, 5'h00, 0, CA_V);
        vt[10] = mk(OP_MFC0, 0, 5'h00, 32'hBFC0_0088, 0, 0, 8'h70, 0, 0, 0, 0, 0, 0, EPC_IN, 5'h00, 0, EPC_V);
        vt[11] = mk(OP_MFC0, 0, 5'h00, 32'hBFC0_008C, 0, 0, 8'h40, 0, 0, 0, 0, 0, 0, EPC_IN, 5'h00, 0, BV_V);
        vt[12] = mk(OP_MFC0, 0, 5'h00, 32'hBFC0_0090, 0, 0, 8'h48, 0, 0, 0, 0, 0, 0, EPC_IN, 5'h00, 0, CNT_V);
        vt[13] = mk(OP_MFC0, 0, 5'h00, 32'hBFC0_0094, 0, 0, 8'h10, 0, 0, 0, 0, 0, 0, EPC_IN, 5'h00, 0, LO0_V);
        vt[14] = mk(OP_MFC0, 0, 5'h00, 32'hBFC0_0098, 0, 0, 8'h18, 0, 0, 0, 0, 0, 0, EPC_IN, 5'h00, 0, LO1_V);
        vt[15] = mk(OP_MFC0, 0, 5'h00, 32'hBFC0_009C, 0, 0, 8'h50, 0, 0, 0, 0, 0, 0, EPC_IN, 5'h00, 0, HI_V);
        vt[16] = mk(OP_MFC0, 0, 5'h00, 32'hBFC0_00A0, 0, 0, 8'h08, 0, 0, 0, 0, 0, 0, EPC_IN, 5'h00, 0, 32'h0);
        vt[17] = mk(OP_MFC0, 0, 5'h00, 32'hBFC0_00A4, 0, 0, 8'h61, 0, 0, 0, 0, 0, 0, EPC_IN, 5'h00, 0, 32'h0);

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst allowin", ws_allowin, 1'b1);
        chk("rst flush", ws_flush, 1'b0);
        chk("rst bus zero", {31'h0, |ws_to_cp0_bus}, 32'h0);
        chk("rst tlb_req", tlb_req, 1'b0);
        chk("rst busy", ws_cp0_busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vt[i]) run_vec(vt[i]);

        // flush cycle ignores the instruction offered alongside it
        @(negedge clk);
        drive(5'h0, 1'b1, 5'h04, 32'hBFC0_1000, 8'h0, 32'h0);
        @(negedge clk);
        drive(OP_MTC0, 1'b0, 5'h0, 32'hBFC0_1004, 8'h58, 32'h77);
        #1;
        chk("flush wb_ex", bo.wb_ex, 1'b1);
        @(negedge clk);
        ms_to_ws_valid = 1'b0;
        #1;
        chk("post-flush mtc0_we", bo.mtc0_we, 1'b0);
        chk("post-flush busy", ws_cp0_busy, 1'b0);
        chk("post-flush allowin", ws_allowin, 1'b1);

        // back-to-back single-cycle commits
        @(negedge clk);
        drive(OP_MTC0, 1'b0, 5'h0, 32'hBFC0_1100, 8'h58, 32'h1);
        @(negedge clk);
        drive(OP_MTC0, 1'b0, 5'h0, 32'hBFC0_1104, 8'h58, 32'h2);
        #1;
        chk("b2b first we", bo.mtc0_we, 1'b1);
        chk("b2b first wdata", bo.c0_wdata, 32'h1);
        @(negedge clk);
        ms_to_ws_valid = 1'b0;
        #1;
        chk("b2b second we", bo.mtc0_we, 1'b1);
        chk("b2b second wdata", bo.c0_wdata, 32'h2);
        @(negedge clk);
        #1;
        chk("b2b idle we", bo.mtc0_we, 1'b0);

`ifdef CP0_TLB_EN
        // mtc0 EntryHi immediately followed by tlbp
        @(negedge clk);
        drive(OP_MTC0, 1'b0, 5'h0, 32'hBFC0_0200, 8'h50, 32'h0040_2005);
        tlb_run(1'b0, 1'b1, 4'd7, 32'h0040_2005, 1'b0, 1'b0);
        tlb_run(1'b0, 1'b0, 4'd0, 32'h0040_2005, 1'b0, 1'b0);
        tlb_run(1'b1, 1'b1, 4'd2, 32'h0040_2005, 1'b0, 1'b0);
        tlb_run(1'b0, 1'b1, 4'd5, 32'h0040_2005, 1'b1, 1'b0);
        tlb_run(1'b1, 1'b1, 4'd1, 32'h0040_2005, 1'b0, 1'b1);
`else
        // without the TLB option, tlbp/tlbr retire in one cycle as no-ops
        @(negedge clk);
        drive(OP_TLBP, 1'b0, 5'h0, 32'hBFC0_0300, 8'h0, 32'h0);
        tlb_found = 1'b1; tlb_index = 4'd9;
        @(negedge clk);
        ms_to_ws_valid = 1'b0;
        #1;
        chk("noTLB tlbp allowin", ws_allowin, 1'b1);
        chk("noTLB tlb_req", tlb_req, 1'b0);
        chk("noTLB tlbp_we", bo.tlbp_we, 1'b0);
        chk("noTLB index_data", bo.index_data, 32'h0);
        chk("noTLB wb_pc", bo.wb_pc, 32'hBFC0_0300);
        @(negedge clk);
        drive(OP_TLBR, 1'b0, 5'h0, 32'hBFC0_0304, 8'h0, 32'h0);
        tlb_r_lo0 = 32'h1234_5678;
        @(negedge clk);
        ms_to_ws_valid = 1'b0;
        #1;
        chk("noTLB tlbr allowin", ws_allowin, 1'b1);
        chk("noTLB tlbr_we", bo.tlbr_we, 1'b0);
        chk("noTLB lo0", bo.lo0, 32'h0);
        @(negedge clk);
        #1;
        chk("noTLB idle busy", ws_cp0_busy, 1'b0);
`endif

        chk("scoreboard drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
